// File: rtl/key_debounce_array.sv
// key_debounce_array: N independent key channels, each synchronised and
// debounced, producing a stable level and press/release/long/repeat pulses.
module key_debounce_array #(
    parameter int N_CH          = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int STABLE_CYCLES = 250000,
    parameter int LONG_CYCLES   = 25000000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_keys,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_long,
    output logic [N_CH-1:0] o_repeat,
    output logic            o_any_press
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    localparam logic INACT = (ACTIVE_LOW != 0);

    localparam logic [1:0] S_REL  = 2'd0;
    localparam logic [1:0] S_PW   = 2'd1;
    localparam logic [1:0] S_HELD = 2'd2;
    localparam logic [1:0] S_RW   = 2'd3;

    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;
    logic [N_CH-1:0] act;

    // Two-flop synchroniser, idling at the released pin level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= {N_CH{INACT}};
            sync2_q <= {N_CH{INACT}};
        end else begin
            sync1_q <= i_keys;
            sync2_q <= sync1_q;
        end
    end

    assign act = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [1:0]        st_q, st_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic [REP_W-1:0]  rep_q, rep_d;
        logic              done_q, done_d;
        logic              lvl_q, lvl_d;
        logic              press_q, press_d;
        logic              rel_q, rel_d;
        logic              long_q, long_d;
        logic              rpt_q, rpt_d;

        // Debounce FSM plus hold timer; timer is frozen outside HELD
        always_comb begin
            st_d    = st_q;
            cnt_d   = cnt_q;
            hold_d  = hold_q;
            rep_d   = rep_q;
            done_d  = done_q;
            lvl_d   = lvl_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            long_d  = 1'b0;
            rpt_d   = 1'b0;
            unique case (st_q)
                S_REL: begin
                    if (act[g]) begin
                        st_d  = S_PW;
                        cnt_d = '0;
                    end
                end
                S_PW: begin
                    if (!act[g]) begin
                        st_d = S_REL;
                    end else if (cnt_q == CNT_LAST) begin
                        st_d    = S_HELD;
                        press_d = 1'b1;
                        lvl_d   = 1'b1;
                        hold_d  = '0;
                        rep_d   = '0;
                        done_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_HELD: begin
                    if (!act[g]) begin
                        st_d  = S_RW;
                        cnt_d = '0;
                    end else begin
                        if (hold_q != HOLD_MAX) begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                        if (!done_q) begin
                            if (hold_q == HOLD_LAST) begin
                                long_d = 1'b1;
                                done_d = 1'b1;
                            end
                        end else if (REPEAT_EN != 0) begin
                            if (rep_q == REP_LAST) begin
                                rpt_d = 1'b1;
                                rep_d = '0;
                            end else begin
                                rep_d = rep_q + REP_W'(1);
                            end
                        end
                    end
                end
                S_RW: begin
                    if (act[g]) begin
                        st_d = S_HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        st_d  = S_REL;
                        rel_d = 1'b1;
                        lvl_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    st_d = S_REL;
                end
            endcase
        end

        // Channel state and registered output pulses
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                st_q    <= S_REL;
                cnt_q   <= '0;
                hold_q  <= '0;
                rep_q   <= '0;
                done_q  <= 1'b0;
                lvl_q   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
                rpt_q   <= 1'b0;
            end else begin
                st_q    <= st_d;
                cnt_q   <= cnt_d;
                hold_q  <= hold_d;
                rep_q   <= rep_d;
                done_q  <= done_d;
                lvl_q   <= lvl_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
                rpt_q   <= rpt_d;
            end
        end

        assign o_level[g]   = lvl_q;
        assign o_press[g]   = press_q;
        assign o_release[g] = rel_q;
        assign o_long[g]    = long_q;
        assign o_repeat[g]  = rpt_q;
    end

    assign o_any_press = |o_press;

endmodule
